cache_ctrl_fsm: RTL and testbench

//  Parametrised controller for a direct-mapped data cache, sitting between the processor data port and a

---
 rtl/cache_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped data cache controller: hit/miss sequencing, multi-word refill,
// dirty-line eviction and write-through or write-back policy toward a fixed-latency memory.
module cache_ctrl_fsm #(
    parameter int MEM_LATENCY = 2,
    parameter int LINE_WORDS  = 4,
    parameter bit WRITE_BACK  = 1'b0,
    localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Strobe,
    input  logic          DRW,
    input  logic          M,
    input  logic          V,
    input  logic          D,
    output logic          DReady,
    output logic          W,
    output logic          WSel,
    output logic          RSel,
    output logic          MStrobe,
    output logic          MRW,
    output logic [IW-1:0] WordIdx,
    output logic          SetDirty,
    output logic          ClrDirty
);

    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LOAD  = LW'(MEM_LATENCY - 1);
    localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RD_HIT     = 4'd1,
        S_EVICT_REQ  = 4'd2,
        S_EVICT_WAIT = 4'd3,
        S_FILL_REQ   = 4'd4,
        S_FILL_WAIT  = 4'd5,
        S_RD_DONE    = 4'd6,
        S_WR_HIT     = 4'd7,
        S_WR_THRU    = 4'd8,
        S_WR_WAIT    = 4'd9
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_beat, w_beat_nxt;
    logic [LW-1:0] r_lat, w_lat_nxt;
    logic          r_drw, w_drw_nxt;
    logic          r_hit, w_hit_nxt;
    logic          r_dmiss, w_dmiss_nxt;
    logic          w_lat_last;
    logic          w_beat_last;
    logic          w_req_hit;
    logic          w_req_dmiss;

    assign w_lat_last  = (r_lat == '0);
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_req_hit   = M & V;
    assign w_req_dmiss = WRITE_BACK & V & D & ~M;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_lat   <= '0;
            r_drw   <= 1'b0;
            r_hit   <= 1'b0;
            r_dmiss <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_lat   <= w_lat_nxt;
            r_drw   <= w_drw_nxt;
            r_hit   <= w_hit_nxt;
            r_dmiss <= w_dmiss_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = r_beat;
        w_lat_nxt   = r_lat;
        w_drw_nxt   = r_drw;
        w_hit_nxt   = r_hit;
        w_dmiss_nxt = r_dmiss;
        DReady      = 1'b0;
        W           = 1'b0;
        WSel        = 1'b0;
        RSel        = 1'b0;
        MStrobe     = 1'b0;
        MRW         = 1'b0;
        WordIdx     = '0;
        SetDirty    = 1'b0;
        ClrDirty    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_beat_nxt = '0;
                if (Strobe) begin
                    w_drw_nxt   = DRW;
                    w_hit_nxt   = w_req_hit;
                    w_dmiss_nxt = w_req_dmiss;
                    // Write-through writes never allocate; everything else refills on a miss
                    if (!DRW && !WRITE_BACK)
                        w_state_nxt = S_WR_THRU;
                    else if (w_req_hit)
                        w_state_nxt = DRW ? S_RD_HIT : S_WR_HIT;
                    else
                        w_state_nxt = w_req_dmiss ? S_EVICT_REQ : S_FILL_REQ;
                end
            end
            S_RD_HIT: begin
                DReady = 1'b1;
            end
            S_EVICT_REQ: begin
                MStrobe     = 1'b1;
                WordIdx     = r_beat;
                w_lat_nxt   = LAT_LOAD;
                w_state_nxt = S_EVICT_WAIT;
            end
            S_EVICT_WAIT: begin
                WordIdx = r_beat;
                if (!w_lat_last) begin
                    w_lat_nxt   = r_lat - LW'(1);
                    w_state_nxt = S_EVICT_WAIT;
                end else if (w_beat_last) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_FILL_REQ;
                end else begin
                    w_beat_nxt  = r_beat + IW'(1);
                    w_state_nxt = S_EVICT_REQ;
                end
            end
            S_FILL_REQ: begin
                MStrobe     = 1'b1;
                MRW         = 1'b1;
                WordIdx     = r_beat;
                w_lat_nxt   = LAT_LOAD;
                w_state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                WordIdx = r_beat;
                if (!w_lat_last) begin
                    w_lat_nxt   = r_lat - LW'(1);
                    w_state_nxt = S_FILL_WAIT;
                end else begin
                    // Memory word arrives on the last wait cycle and is written straight into the array
                    W        = 1'b1;
                    WSel     = 1'b1;
                    ClrDirty = 1'b1;
                    if (w_beat_last) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = r_drw ? S_RD_DONE : S_WR_HIT;
                    end else begin
                        w_beat_nxt  = r_beat + IW'(1);
                        w_state_nxt = S_FILL_REQ;
                    end
                end
            end
            S_RD_DONE: begin
                DReady = 1'b1;
            end
            S_WR_HIT: begin
                W        = 1'b1;
                SetDirty = 1'b1;
                DReady   = 1'b1;
            end
            S_WR_THRU: begin
                MStrobe     = 1'b1;
                W           = r_hit;
                w_lat_nxt   = LAT_LOAD;
                w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!w_lat_last) begin
                    w_lat_nxt   = r_lat - LW'(1);
                    w_state_nxt = S_WR_WAIT;
                end else begin
                    DReady = 1'b1;
                end
            end
            default: begin
                w_beat_nxt = '0;
                w_lat_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: one write-through and one write-back instance, directed table,
// randomized transactions against a schedule-building reference model, and reset/Strobe corner cases.
module tb_cache_ctrl_fsm;

    localparam int LAT = 2;
    localparam int NW  = 4;

    localparam logic [9:0] M_ALL  = 10'h3FF;
    localparam logic [9:0] M_CTL  = 10'h3E3;
    localparam logic [9:0] M_FILL = 10'h3EF;
    localparam logic [9:0] M_WT   = 10'h3F3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stb_wt = 1'b0, stb_wb = 1'b0;
    logic drw = 1'b0, m = 1'b0, v = 1'b0, d = 1'b0;

    logic wt_dr, wt_w, wt_ws, wt_rs, wt_ms, wt_mrw, wt_sd, wt_cd;
    logic wb_dr, wb_w, wb_ws, wb_rs, wb_ms, wb_mrw, wb_sd, wb_cd;
    logic [1:0] wt_idx, wb_idx;
    logic [9:0] o_wt, o_wb;

    int n_vec = 0;
    int n_bad = 0;

    logic [9:0] eq[$];
    logic [9:0] mq[$];

    typedef struct {
        int wb;
        bit rd, mm, vv, dd;
        int dr_cyc;
        int n_ms;
        int n_w;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    // Output vector: {DReady, W, WSel, RSel, MStrobe, MRW, WordIdx[1:0], SetDirty, ClrDirty}
    assign o_wt = {wt_dr, wt_w, wt_ws, wt_rs, wt_ms, wt_mrw, wt_idx, wt_sd, wt_cd};
    assign o_wb = {wb_dr, wb_w, wb_ws, wb_rs, wb_ms, wb_mrw, wb_idx, wb_sd, wb_cd};

    cache_ctrl_fsm #(.MEM_LATENCY(LAT), .LINE_WORDS(NW), .WRITE_BACK(1'b0)) u_wt (
        .clk(clk), .reset(rst_n), .Strobe(stb_wt), .DRW(drw), .M(m), .V(v), .D(d),
        .DReady(wt_dr), .W(wt_w), .WSel(wt_ws), .RSel(wt_rs), .MStrobe(wt_ms), .MRW(wt_mrw),
        .WordIdx(wt_idx), .SetDirty(wt_sd), .ClrDirty(wt_cd));

    cache_ctrl_fsm #(.MEM_LATENCY(LAT), .LINE_WORDS(NW), .WRITE_BACK(1'b1)) u_wb (
        .clk(clk), .reset(rst_n), .Strobe(stb_wb), .DRW(drw), .M(m), .V(v), .D(d),
        .DReady(wb_dr), .W(wb_w), .WSel(wb_ws), .RSel(wb_rs), .MStrobe(wb_ms), .MRW(wb_mrw),
        .WordIdx(wb_idx), .SetDirty(wb_sd), .ClrDirty(wb_cd));

    function automatic logic [9:0] outv(input int wb);
        return (wb != 0) ? o_wb : o_wt;
    endfunction

    function automatic logic [9:0] ov(input bit dr, input bit w, input bit ws, input bit ms,
                                      input bit mrw, input int idx, input bit sd, input bit cd);
        logic [1:0] ix;
        ix = idx[1:0];
        return {dr, w, ws, 1'b0, ms, mrw, ix, sd, cd};
    endfunction

    function automatic void push(input logic [9:0] e, input logic [9:0] mk);
        eq.push_back(e);
        mq.push_back(mk);
    endfunction

    // Expected per-cycle outputs from cycle 1 after accept, ending with one IDLE cycle
    function automatic void build(input int wb, input bit rd, input bit mm, input bit vv, input bit dd);
        bit hit, dm;
        eq.delete();
        mq.delete();
        hit = mm && vv;
        dm  = (wb != 0) && vv && dd && !mm;
        if (rd && hit) begin
            push(ov(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        end else if (!rd && wb != 0 && hit) begin
            push(ov(1, 1, 0, 0, 0, 0, 1, 0), M_CTL);
        end else if (!rd && wb == 0) begin
            push(ov(0, hit, 0, 1, 0, 0, 0, 0), M_WT);
            for (int i = 0; i < LAT - 1; i++) push('0, M_CTL);
            push(ov(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        end else begin
            if (dm) begin
                for (int k = 0; k < NW; k++) begin
                    push(ov(0, 0, 0, 1, 0, k, 0, 0), M_ALL);
                    for (int i = 0; i < LAT; i++) push('0, M_CTL);
                end
            end
            for (int k = 0; k < NW; k++) begin
                push(ov(0, 0, 0, 1, 1, k, 0, 0), M_ALL);
                for (int i = 0; i < LAT - 1; i++) push('0, M_CTL);
                push(ov(0, 1, 1, 0, 0, k, 0, 1), M_FILL);
            end
            if (rd) push(ov(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
            else    push(ov(1, 1, 0, 0, 0, 0, 1, 0), M_CTL);
        end
        push('0, M_ALL);
    endfunction

    task automatic check_v(input string name, input logic [9:0] got, input logic [9:0] exp,
                           input logic [9:0] mk);
        n_vec++;
        if ((got & mk) !== (exp & mk)) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (care %b) at %0t", name, got, exp, mk, $time);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_stb(input int wb, input bit val);
        if (wb != 0) stb_wb = val;
        else         stb_wt = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        int got_dr, n_ms, n_w;
        logic [9:0] o;
        vec_t r;
        r = tbl[idx];
        got_dr = -1;
        n_ms = 0;
        n_w = 0;
        drw = r.rd; m = r.mm; v = r.vv; d = r.dd;
        set_stb(r.wb, 1'b1);
        for (int c = 1; c <= 60; c++) begin
            tick();
            set_stb(r.wb, 1'b0);
            o = outv(r.wb);
            if (o[5]) n_ms++;
            if (o[8]) n_w++;
            if (o[9]) begin
                got_dr = c;
                break;
            end
        end
        tick();
        check_i($sformatf("tbl%0d_dready_cycle", idx), got_dr, r.dr_cyc);
        check_i($sformatf("tbl%0d_mstrobe_count", idx), n_ms, r.n_ms);
        check_i($sformatf("tbl%0d_w_count", idx), n_w, r.n_w);
    endtask

    task automatic rand_txn(input int t);
        int wb;
        bit rd, mm, vv, dd;
        wb = int'($urandom_range(0, 1));
        rd = 1'($urandom);
        mm = 1'($urandom);
        vv = 1'($urandom);
        dd = 1'($urandom);
        build(wb, rd, mm, vv, dd);
        drw = rd; m = mm; v = vv; d = dd;
        set_stb(wb, 1'b1);
        check_v($sformatf("rnd%0d_accept", t), outv(wb), '0, M_ALL);
        for (int c = 0; c < eq.size(); c++) begin
            tick();
            // Strobe and line status toggle freely mid-operation; they must be ignored outside IDLE
            set_stb(wb, (c == eq.size() - 1) ? 1'b0 : 1'($urandom));
            drw = 1'($urandom); m = 1'($urandom); v = 1'($urandom); d = 1'($urandom);
            check_v($sformatf("rnd%0d_wb%0d_cyc%0d", t, wb, c + 1), outv(wb), eq[c], mq[c]);
        end
        set_stb(wb, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n_ms, first_dr;

        tbl[0]  = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0};
        tbl[1]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 13, 4, 4};
        tbl[2]  = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 25, 8, 4};
        tbl[3]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1, 1};
        tbl[4]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1, 0};
        tbl[5]  = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1};
        tbl[6]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 13, 4, 5};
        tbl[7]  = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 25, 8, 5};
        tbl[8]  = '{1, 1'b1, 1'b1, 1'b0, 1'b1, 13, 4, 4};
        tbl[9]  = '{0, 1'b1, 1'b0, 1'b1, 1'b1, 13, 4, 4};
        tbl[10] = '{1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0};
        tbl[11] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0};

        #12;
        check_v("reset_wt_outputs", o_wt, '0, M_ALL);
        check_v("reset_wb_outputs", o_wb, '0, M_ALL);
        #10 rst_n = 1'b1;
        tick();
        check_v("post_reset_wt_idle", o_wt, '0, M_ALL);
        check_v("post_reset_wb_idle", o_wb, '0, M_ALL);

        for (int i = 0; i < 12; i++) run_vec(i);

        for (int t = 0; t < 40; t++) rand_txn(t);

        // Reset in cycle 5 of a write-through read miss
        drw = 1'b1; m = 1'b0; v = 1'b1; d = 1'b0;
        stb_wt = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            stb_wt = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_v("midop_reset_outputs", o_wt, '0, M_ALL);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_v("after_reset_idle", o_wt, '0, M_ALL);

        // Read hit with Strobe held: DReady, IDLE, then a second accept
        drw = 1'b1; m = 1'b1; v = 1'b1;
        stb_wt = 1'b1;
        tick();
        check_v("held_hit_c1_dready", o_wt, ov(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        tick();
        check_v("held_hit_c2_idle", o_wt, '0, M_ALL);
        tick();
        check_v("held_hit_c3_dready", o_wt, ov(1, 0, 0, 0, 0, 0, 0, 0), M_CTL);
        stb_wt = 1'b0;
        tick();

        // Read miss with Strobe held high throughout: no re-trigger before completion
        m = 1'b0;
        stb_wt = 1'b1;
        n_ms = 0;
        first_dr = -1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 13) stb_wt = 1'b0;
            if (o_wt[5]) n_ms++;
            if (o_wt[9] && first_dr < 0) first_dr = c;
        end
        check_i("held_miss_mstrobe_count", n_ms, 4);
        check_i("held_miss_dready_cycle", first_dr, 13);
        tick();
        check_v("held_miss_idle", o_wt, '0, M_ALL);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
